// File: rtl/sinc_n_decimator.sv
// sinc^N (CIC) decimator for a 1-bit sigma-delta bitstream, runtime-selectable ratio 2^osr.
// Latency: out/outValid register one clk after the terminal-count en sample.
// No backpressure: en gates every state update, outValid is a one-clk strobe.
module sinc_n_decimator #(
   parameter int ORDER        = 3,
   parameter int LOG2_OSR_MAX = 5,
   localparam int OUT_W       = ORDER * LOG2_OSR_MAX + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [2:0]              osrSel,
   input  logic                    in,
   output logic signed [OUT_W-1:0] out,
   output logic                    outValid
);

   localparam int ACC_W  = OUT_W + 1;
   localparam int SH_MAX = ORDER * (LOG2_OSR_MAX - 1);
   localparam int WIDE_W = ACC_W + SH_MAX;
   localparam int CNT_W  = LOG2_OSR_MAX;
   localparam logic signed [WIDE_W-1:0] SAT_P = WIDE_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [WIDE_W-1:0] SAT_N = -SAT_P;

   typedef enum logic {SETTLE, RUN} state_t;

   logic signed [ACC_W-1:0]  r_int [ORDER];
   logic signed [ACC_W-1:0]  r_dly [ORDER];
   logic [CNT_W-1:0]         r_cnt;
   logic [2:0]               r_osr;
   logic [2:0]               r_settle;
   state_t                   r_state;

   logic [2:0]               w_osr_new;
   logic                     w_chg;
   logic                     w_tc;
   logic [CNT_W-1:0]         w_tc_val;
   logic signed [ACC_W-1:0]  w_x;
   logic signed [ACC_W-1:0]  w_cin [ORDER];
   logic signed [ACC_W-1:0]  w_comb;
   logic signed [WIDE_W-1:0] w_wide;
   logic signed [WIDE_W-1:0] w_scaled;
   logic signed [OUT_W-1:0]  w_sat;
   int                       w_shift;

   // Bitstream sample mapped to +1 / -1 at accumulator width
   assign w_x = in ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};

   // Clamp the requested ratio to 1..LOG2_OSR_MAX
   always_comb begin
      w_osr_new = osrSel;
      if (osrSel == 3'd0) begin
         w_osr_new = 3'd1;
      end else if (int'(osrSel) > LOG2_OSR_MAX) begin
         w_osr_new = 3'(LOG2_OSR_MAX);
      end
   end

   // Terminal count value 2^osr-1 as a low-bit mask; a ratio change suppresses TC
   always_comb begin
      w_tc_val = '0;
      for (int b = 0; b < CNT_W; b++) begin
         w_tc_val[b] = (b < int'(r_osr));
      end
   end

   assign w_chg = en && (w_osr_new != r_osr);
   assign w_tc  = en && !w_chg && (r_cnt == w_tc_val);

   // Comb cascade on the last integrator; w_cin[k] is what delay k captures at TC
   always_comb begin
      logic signed [ACC_W-1:0] v;
      v = r_int[ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
         w_cin[k] = v;
         v        = v - r_dly[k];
      end
      w_comb = v;
   end

   // Normalise to full scale and saturate symmetrically
   always_comb begin
      w_shift  = ORDER * (LOG2_OSR_MAX - int'(r_osr));
      w_wide   = WIDE_W'(w_comb);
      w_scaled = w_wide <<< w_shift;
      if (w_scaled > SAT_P) begin
         w_sat = SAT_P[OUT_W-1:0];
      end else if (w_scaled < SAT_N) begin
         w_sat = SAT_N[OUT_W-1:0];
      end else begin
         w_sat = w_scaled[OUT_W-1:0];
      end
   end

   // Integrator chain, modular at ACC_W, advances once per en sample
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < ORDER; k++) begin
            r_int[k] <= '0;
         end
      end else if (en) begin
         r_int[0] <= r_int[0] + w_x;
         for (int k = 1; k < ORDER; k++) begin
            r_int[k] <= r_int[k] + r_int[k-1];
         end
      end
   end

   // Comb delay lines update only at terminal count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < ORDER; k++) begin
            r_dly[k] <= '0;
         end
      end else if (w_tc) begin
         for (int k = 0; k < ORDER; k++) begin
            r_dly[k] <= w_cin[k];
         end
      end
   end

   // Decimation counter, ratio register, settle FSM and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_osr    <= '0;
         r_settle <= '0;
         r_state  <= SETTLE;
         out      <= '0;
         outValid <= 1'b0;
      end else begin
         outValid <= 1'b0;
         if (w_chg) begin
            // The changing sample is position 0 of the new frame
            r_osr    <= w_osr_new;
            r_cnt    <= CNT_W'(1);
            r_settle <= '0;
            r_state  <= SETTLE;
         end else if (w_tc) begin
            r_cnt <= '0;
            out   <= w_sat;
            if (r_state == RUN) begin
               outValid <= 1'b1;
            end else if (int'(r_settle) == ORDER - 1) begin
               r_settle <= '0;
               r_state  <= RUN;
            end else begin
               r_settle <= r_settle + 3'd1;
            end
         end else if (en) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule
